mult_issue_ctrl: RTL and testbench

Issue scheduler for the single pipelined multiplier (fixed 5-cycle latency, one op per cycle).
- Round-robin arbitration between N_REQ reservation-station requesters.
- Drives the multiplier operands and op type, and carries destination tags alongside the pipeline.
- Collects results into a small result FIFO and presents them to writeback with valid/ready.
- Credit gating guarantees no result is ever dropped, because the multiplier cannot stall.

---
 rtl/mult_issue_ctrl_pkg.sv | 24 ++
 rtl/mult_result_fifo.sv | 53 +++++
 rtl/mult_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_issue_ctrl_pkg.sv
// Shared types and constants for the multiplier issue controller.
// Provides mult_type_t, default latency/tag/ROB widths and a wrap helper.
package mult_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        MULT   = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_type_t;

    localparam int MULT_LATENCY = 5;
    localparam int PREG_TAG_W   = 6;
    localparam int ROB_IDX_W    = 5;

    // (base + off) mod n, for off < n and base < n.
    function automatic int wrap_inc(int base, int off, int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// Result FIFO between the multiplier tag pipe and writeback.
// Ports: clock, reset (sync, active-low), clear, push/push_data, pop, head, count.
module mult_result_fifo #(
    parameter int W     = 43,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic          empty;
    logic          take;

    assign empty = (count == '0);
    assign take  = pop && !empty;
    // Zero when empty so writeback sees clean outputs after reset/flush.
    assign head  = empty ? '0 : mem[rptr];

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + AW'(1);
            end
            if (take) rptr <= rptr + AW'(1);
            count <= count + CNT_W'(push) - CNT_W'(take);
        end
    end

    // Credit gating upstream makes an overflowing push impossible.
    a_no_overflow : assert property (
        @(posedge clock) disable iff (!reset || clear)
        !(push && !take && count == FULL)
    );

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue scheduler for the pipelined multiplier: round-robin grant, tag pipe,
// credit-gated result FIFO to writeback. Ports: clock, reset (sync, active-low),
// flush, req_* (per requester), mul_* (to/from multiplier), wb_* (writeback).
// Optional MULT_PERF_CNT_EN adds perf_issued / perf_credit_stall counters.
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int LATENCY    = MULT_LATENCY,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = PREG_TAG_W,
    parameter int ROB_W      = ROB_IDX_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*2-1:0]     req_type,
    input  logic [N_REQ*32-1:0]    req_in1,
    input  logic [N_REQ*32-1:0]    req_in2,
    input  logic [N_REQ*TAG_W-1:0] req_tag,
    input  logic [N_REQ*ROB_W-1:0] req_rob,
    output logic                   mul_valid,
    output mult_type_t             mul_type,
    output logic [31:0]            mul_in1,
    output logic [31:0]            mul_in2,
    input  logic [31:0]            mul_out,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [31:0]            wb_data,
    output logic [TAG_W-1:0]       wb_tag,
    output logic [ROB_W-1:0]       wb_rob
`ifdef MULT_PERF_CNT_EN
    ,
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_credit_stall
`endif
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int META_W = TAG_W + ROB_W;

    logic [PTR_W-1:0]               rr_ptr;
    logic [PTR_W-1:0]               gsel;
    logic                           any_valid;
    logic                           credit_ok;
    logic                           can_issue;
    logic [N_REQ-1:0]               grant;
    logic [TAG_W-1:0]               sel_tag;
    logic [ROB_W-1:0]               sel_rob;
    logic [LATENCY-1:0]             pipe_v;
    logic [LATENCY-1:0][META_W-1:0] pipe_meta;
    logic [CNT_W-1:0]               fifo_count;
    logic [32+META_W-1:0]           head;

    // Every op in the tag pipe already owns a FIFO slot; pops this
    // cycle are not credited back until the count register updates.
    assign credit_ok = (int'(fifo_count) + $countones(pipe_v)) < FIFO_DEPTH;
    assign can_issue = reset && !flush && credit_ok;

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        gsel      = '0;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_inc(int'(rr_ptr), k, N_REQ)]) begin
                gsel      = PTR_W'(wrap_inc(int'(rr_ptr), k, N_REQ));
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant    = '0;
        mul_type = MULT;
        mul_in1  = '0;
        mul_in2  = '0;
        sel_tag  = '0;
        sel_rob  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (can_issue && any_valid && int'(gsel) == k) begin
                grant[k] = 1'b1;
                mul_type = mult_type_t'(req_type[2*k +: 2]);
                mul_in1  = req_in1[32*k +: 32];
                mul_in2  = req_in2[32*k +: 32];
                sel_tag  = req_tag[TAG_W*k +: TAG_W];
                sel_rob  = req_rob[ROB_W*k +: ROB_W];
            end
        end
    end

    assign req_ready = grant;
    assign mul_valid = |grant;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (mul_valid) begin
            rr_ptr <= PTR_W'(wrap_inc(int'(gsel), 1, N_REQ));
        end
    end

    // Flush only kills valid bits; stale meta is harmless.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            pipe_v <= '0;
        end else begin
            pipe_v <= {pipe_v[LATENCY-2:0], mul_valid};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pipe_meta <= '0;
        end else begin
            pipe_meta <= {pipe_meta[LATENCY-2:0], {sel_tag, sel_rob}};
        end
    end

    mult_result_fifo #(
        .W     (32 + META_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (pipe_v[LATENCY-1]),
        .push_data ({mul_out, pipe_meta[LATENCY-1]}),
        .pop       (wb_valid && wb_ready),
        .head      (head),
        .count     (fifo_count)
    );

    assign wb_valid = (fifo_count != '0);
    assign {wb_data, wb_tag, wb_rob} = head;

`ifdef MULT_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_issued       <= '0;
            perf_credit_stall <= '0;
        end else begin
            if (mul_valid) perf_issued <= perf_issued + 32'd1;
            if (any_valid && !flush && !credit_ok)
                perf_credit_stall <= perf_credit_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mult_issue_ctrl;
    import mult_issue_ctrl_pkg::*;

    localparam int N  = 2;
    localparam int L  = 5;
    localparam int D  = 4;
    localparam int TW = 6;
    localparam int RW = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    req_type = '0;
    logic [32*N-1:0]   req_in1 = '0;
    logic [32*N-1:0]   req_in2 = '0;
    logic [TW*N-1:0]   req_tag = '0;
    logic [RW*N-1:0]   req_rob = '0;
    logic              mul_valid;
    logic [1:0]        mul_type;
    logic [31:0]       mul_in1;
    logic [31:0]       mul_in2;
    logic [31:0]       mul_out;
    logic              wb_valid;
    logic              wb_ready = 1'b1;
    logic [31:0]       wb_data;
    logic [TW-1:0]     wb_tag;
    logic [RW-1:0]     wb_rob;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mult_issue_ctrl #(
        .N_REQ(N), .LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW), .ROB_W(RW)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_in1(req_in1), .req_in2(req_in2),
        .req_tag(req_tag), .req_rob(req_rob),
        .mul_valid(mul_valid), .mul_type(mul_type),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_tag(wb_tag), .wb_rob(wb_rob)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mulfn(logic [1:0] t, logic [31:0] a,
                                          logic [31:0] b);
        logic [63:0] p;
        case (t)
            2'd0: p = {32'b0, a} * {32'b0, b};
            2'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            2'd2: p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (t == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // External multiplier: fixed L-cycle pipeline.
    logic [31:0] mp [L];
    always @(posedge clock) begin
        mp[0] <= mulfn(mul_type, mul_in1, mul_in2);
        for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
    assign mul_out = mp[L-1];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: ops in flight and ops visible at writeback.
    typedef struct {
        logic [31:0]   res;
        logic [TW-1:0] tag;
        logic [RW-1:0] rob;
        int            due;
    } op_t;

    op_t infl[$];
    op_t wbq[$];
    int  rr_m = 0;
    bit  model_ok = 0;

    function automatic int exp_grant();
        if (!reset || flush) return -1;
        if (wbq.size() + infl.size() >= D) return -1;
        for (int k = 0; k < N; k++) begin
            int i = (rr_m + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clock) begin
        int g;
        logic [N-1:0] er;
        if (model_ok) begin
            g  = exp_grant();
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("mul_valid", 64'(mul_valid), 64'(g >= 0));
            if (g >= 0) begin
                chk("mul_type", 64'(mul_type), 64'(req_type[2*g +: 2]));
                chk("mul_in1", 64'(mul_in1), 64'(req_in1[32*g +: 32]));
                chk("mul_in2", 64'(mul_in2), 64'(req_in2[32*g +: 32]));
            end else if (!reset) begin
                chk("mul_ops_rst",
                    64'({mul_type, mul_in1, mul_in2}), 64'(0));
            end
            chk("wb_valid", 64'(wb_valid), 64'(wbq.size() > 0));
            if (wbq.size() > 0) begin
                chk("wb_data", 64'(wb_data), 64'(wbq[0].res));
                chk("wb_tag", 64'(wb_tag), 64'(wbq[0].tag));
                chk("wb_rob", 64'(wb_rob), 64'(wbq[0].rob));
            end
        end
    end

    always @(posedge clock) begin
        int g;
        op_t o;
        if (!reset) begin
            infl.delete();
            wbq.delete();
            rr_m     = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (flush) begin
                infl.delete();
                wbq.delete();
            end else begin
                g = exp_grant();
                if (wbq.size() > 0 && wb_ready) void'(wbq.pop_front());
                if (g >= 0) begin
                    o.res = mulfn(req_type[2*g +: 2], req_in1[32*g +: 32],
                                  req_in2[32*g +: 32]);
                    o.tag = req_tag[TW*g +: TW];
                    o.rob = req_rob[RW*g +: RW];
                    o.due = cyc + L + 1;
                    infl.push_back(o);
                    rr_m = (g + 1) % N;
                end
                while (infl.size() > 0 && infl[0].due == cyc + 1)
                    wbq.push_back(infl.pop_front());
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] t,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [TW-1:0] tg, input logic [RW-1:0] rb);
        req_valid[i]          = v;
        req_type[2*i +: 2]    = t;
        req_in1[32*i +: 32]   = a;
        req_in2[32*i +: 32]   = b;
        req_tag[TW*i +: TW]   = tg;
        req_rob[RW*i +: RW]   = rb;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] exp3 [3];
    int seq[$];
    int launched;
    int seen;

    initial begin
        exp3[0] = 32'h4000_0000;
        exp3[1] = 32'hFFFF_FFFF;
        exp3[2] = 32'hFFFF_FFFE;

        // Single MULT: latency and result.
        do_reset();
        wb_ready = 1'b1;
        set_req(0, 1'b1, 2'd0, 32'd10, 32'd11, 6'd3, 5'd7);
        #1 chk("t1_ready", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = '0;
        repeat (4) step();
        #1 chk("t1_wb_early", 64'(wb_valid), 64'(0));
        step();
        #1 chk("t1_wb_valid", 64'(wb_valid), 64'(1));
        chk("t1_wb_data", 64'(wb_data), 64'(110));
        chk("t1_wb_tag", 64'(wb_tag), 64'(3));
        chk("t1_wb_rob", 64'(wb_rob), 64'(7));

        // Back-to-back high-half variants.
        do_reset();
        set_req(0, 1'b1, 2'd1, 32'h8000_0000, 32'h8000_0000, 6'd1, 5'd1);
        step();
        set_req(0, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'd2, 6'd2, 5'd2);
        step();
        set_req(0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 5'd3);
        step();
        req_valid = '0;
        repeat (2) step();
        #1 chk("t2_wb_early", 64'(wb_valid), 64'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            #1 chk("t2_wb_valid", 64'(wb_valid), 64'(1));
            chk("t2_wb_data", 64'(wb_data), 64'(exp3[i]));
        end

        // Round-robin fairness.
        do_reset();
        set_req(0, 1'b1, 2'd0, 32'd2, 32'd3, 6'd10, 5'd10);
        set_req(1, 1'b1, 2'd0, 32'd4, 32'd5, 6'd11, 5'd11);
        seq.delete();
        for (int c = 0; c < 40 && seq.size() < 6; c++) begin
            #1 if (req_ready != '0) seq.push_back(req_ready[1] ? 1 : 0);
            step();
        end
        chk("t3_launches", 64'(seq.size() >= 6), 64'(1));
        for (int i = 0; i < 4 && i < seq.size(); i++)
            chk("t3_order", 64'(seq[i]), 64'(i % 2));
        req_valid = '0;

        // Backpressure: credits cap launches at FIFO_DEPTH.
        do_reset();
        wb_ready = 1'b0;
        launched = 0;
        repeat (20) begin
            set_req(0, 1'b1, 2'd0, 32'(launched + 1), 32'd100,
                    TW'(launched + 1), RW'(launched + 1));
            #1 if (req_ready[0]) launched++;
            step();
        end
        chk("t4_launches", 64'(launched), 64'(4));
        #1 chk("t4_ready_blocked", 64'(req_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            chk("t4_wb_valid", 64'(wb_valid), 64'(1));
            chk("t4_wb_hold", 64'(wb_data), 64'(100));
            chk("t4_wb_tag", 64'(wb_tag), 64'(1));
            step();
            #1;
        end
        wb_ready = 1'b1;
        for (int c = 0; c < 40 && launched < 6; c++) begin
            set_req(0, 1'b1, 2'd0, 32'(launched + 1), 32'd100,
                    TW'(launched + 1), RW'(launched + 1));
            #1 if (req_ready[0]) launched++;
            step();
        end
        chk("t4_resume", 64'(launched), 64'(6));
        req_valid = '0;
        repeat (20) step();
        #1 chk("t4_drained", 64'(wb_valid), 64'(0));

        // Flush drops in-flight ops; later op returns normally.
        do_reset();
        set_req(0, 1'b1, 2'd0, 32'd3, 32'd4, 6'd5, 5'd1);
        step();
        set_req(0, 1'b1, 2'd0, 32'd5, 32'd6, 6'd6, 5'd2);
        step();
        req_valid = '0;
        step();
        flush = 1'b1;
        set_req(1, 1'b1, 2'd0, 32'd1, 32'd1, 6'd1, 5'd1);
        #1 chk("t5_flush_ready", 64'(req_ready), 64'(0));
        step();
        flush     = 1'b0;
        req_valid = '0;
        seen = 0;
        repeat (10) begin
            #1 if (wb_valid) seen++;
            step();
        end
        chk("t5_no_wb", 64'(seen), 64'(0));
        set_req(1, 1'b1, 2'd0, 32'd7, 32'd6, 6'd9, 5'd3);
        #1 chk("t5_ready", 64'(req_ready), 64'(2'b10));
        step();
        req_valid = '0;
        repeat (5) step();
        #1 chk("t5_wb_valid", 64'(wb_valid), 64'(1));
        chk("t5_wb_data", 64'(wb_data), 64'(42));
        chk("t5_wb_tag", 64'(wb_tag), 64'(9));
        chk("t5_wb_rob", 64'(wb_rob), 64'(3));

        // Reset with ops in flight.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 2'd0, 32'(i + 2), 32'd9, TW'(i), RW'(i));
            step();
        end
        reset = 1'b0;
        #1 chk("t6_rst_ready", 64'(req_ready), 64'(0));
        step();
        reset     = 1'b1;
        req_valid = '0;
        #1 chk("t6_mul", 64'({mul_valid, mul_in1, req_ready}), 64'(0));
        chk("t6_wb", 64'({wb_valid, wb_tag, wb_rob}), 64'(0));
        chk("t6_wb_data", 64'(wb_data), 64'(0));
        seen = 0;
        repeat (10) begin
            #1 if (wb_valid) seen++;
            step();
        end
        chk("t6_no_wb", 64'(seen), 64'(0));

        // Randomized traffic against the model.
        repeat (3000) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        rnd_op(), rnd_op(), TW'($urandom), RW'($urandom));
            wb_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 299) != 0);
            step();
        end

        reset     = 1'b1;
        flush     = 1'b0;
        wb_ready  = 1'b1;
        req_valid = '0;
        repeat (10) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
